// File: rtl/pe_feed_pkg.sv
// Shared types and constants for the PE row feed sequencer.
package pe_feed_pkg;

  // Controller phases: waiting for a block, accepting beats, flushing zeros.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2
  } pe_feed_state_t;

  // Default width of the block-length field.
  localparam int PE_FEED_LEN_WIDTH = 16;

  // Width of the stall performance counter.
  localparam int PE_FEED_STALL_W = 32;

endpackage

// File: rtl/pe_feed_ctrl.sv
// Sequencer for the enable-gated register chain feeding one PE row.
// Accepts k_len beats over valid/ready, advances the external chain with a
// replicated enable, then flushes it with zeros and pulses done once empty.
// Optional feature: define PE_FEED_PERF_EN to build the stall_cycles counter;
// otherwise stall_cycles is tied to zero.
module pe_feed_ctrl
  import pe_feed_pkg::*;
#(
  parameter int NUM_STAGES = 16,
  parameter int LEN_WIDTH  = PE_FEED_LEN_WIDTH,
  parameter int MAX_FANOUT = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [LEN_WIDTH-1:0]       k_len,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       pe_stall,
  output logic [NUM_STAGES-1:0]      shift_ena,
  output logic                       zero_fill,
  output logic                       out_valid,
  output logic                       busy,
  output logic                       done,
  output logic [PE_FEED_STALL_W-1:0] stall_cycles
);

  // The drain counter must hold the value NUM_STAGES itself.
  localparam int DCW = $clog2(NUM_STAGES + 1);

  // Reject configurations the tracker shift cannot express.
  generate
    if (NUM_STAGES < 2 || MAX_FANOUT < 1) begin : g_param_check
      $error("pe_feed_ctrl: NUM_STAGES must be >= 2 and MAX_FANOUT >= 1");
    end
  endgenerate

  pe_feed_state_t        state_q, state_d;
  logic [LEN_WIDTH-1:0]  beats_left_q, beats_left_d;
  logic [DCW-1:0]        drain_cnt_q, drain_cnt_d;
  logic [NUM_STAGES-1:0] vld_q, vld_d;
  logic                  done_q, done_d;

  // Single advance decision shared by every chain stage; heavy fanout.
  (* max_fanout = MAX_FANOUT *) logic adv;

  // Next-state, handshake and chain control decode.
  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    drain_cnt_d  = drain_cnt_q;
    vld_d        = vld_q;
    done_d       = 1'b0;
    in_ready     = 1'b0;
    zero_fill    = 1'b0;
    adv          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (k_len != '0) begin
            beats_left_d = k_len;
            state_d      = ST_FEED;
          end else begin
            // Empty block completes immediately.
            done_d = 1'b1;
          end
        end
      end

      ST_FEED: begin
        in_ready = !pe_stall;
        adv      = in_valid && !pe_stall;
        if (adv) begin
          beats_left_d = beats_left_q - 1'b1;
          if (beats_left_q == LEN_WIDTH'(1)) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = DCW'(NUM_STAGES);
          end
        end
      end

      ST_DRAIN: begin
        zero_fill = 1'b1;
        adv       = !pe_stall;
        if (adv) begin
          drain_cnt_d = drain_cnt_q - 1'b1;
          if (drain_cnt_q == DCW'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Live-data tracker moves in lockstep with the chain.
    if (adv) begin
      vld_d = {vld_q[NUM_STAGES-2:0], !zero_fill};
    end
  end

  // State, counters, tracker and done pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      beats_left_q <= '0;
      drain_cnt_q  <= '0;
      vld_q        <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      drain_cnt_q  <= drain_cnt_d;
      vld_q        <= vld_d;
      done_q       <= done_d;
    end
  end

  // Replicate the advance enable, one copy per chain stage.
  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_shift_ena
      assign shift_ena[gi] = adv;
    end
  endgenerate

  assign out_valid = vld_q[NUM_STAGES-1];
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

`ifdef PE_FEED_PERF_EN
  localparam logic [PE_FEED_STALL_W-1:0] STALL_MAX = '1;

  logic [PE_FEED_STALL_W-1:0] stall_q, stall_d;

  // Count non-advancing busy cycles; restart on each accepted start.
  always_comb begin
    stall_d = stall_q;
    if (state_q == ST_IDLE) begin
      if (start) begin
        stall_d = '0;
      end
    end else if (!adv && stall_q != STALL_MAX) begin
      stall_d = stall_q + 1'b1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule
